// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq -- iterative RV32M multiply/divide sequencer for the EX stage.
//
// Runs a radix-2 shift-add multiply or a restoring divide, one bit per cycle,
// on operand magnitudes, then applies sign correction and selects the
// requested word. While busy it holds the upstream pipeline through stall.
//
// Optional feature: define MULDIV_EARLY_OUT_EN to send divide-by-zero,
// signed overflow and multiply-by-zero straight from IDLE to DONE.
//
// Ports:
//   clk       in   1   pipeline clock, rising edge
//   reset     in   1   synchronous active-high reset, clears all state
//   start     in   1   M-extension instruction present in EX
//   func3     in   3   RV32M selector (MUL..REMU)
//   opA       in  32   forwarded rs1 value
//   opB       in  32   forwarded rs2 value
//   rdIn      in   5   destination register of the requesting instruction
//   flush     in   1   abort current operation
//   stall     out  1   hold IF/ID and ID/EX registers
//   busy      out  1   sequencer not idle
//   done      out  1   one-cycle pulse, result/resultRd valid
//   result    out 32   registered operation result
//   resultRd  out  5   registered destination register
module ex_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rdIn,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  resultRd
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;

    logic [2:0]  func3_q;
    logic [4:0]  rd_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic        div0_q;
    logic [31:0] b_mag_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic [4:0]  result_rd_q;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic        sgn_a, sgn_b;
    logic        neg_a, neg_b;
    logic [31:0] a_mag, b_mag;
    logic        accept;

    always_comb begin
        sgn_a = (func3 == 3'b001) || (func3 == 3'b010) ||
                (func3 == 3'b100) || (func3 == 3'b110);
        sgn_b = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
        neg_a = sgn_a & opA[31];
        neg_b = sgn_b & opB[31];
        a_mag = neg_a ? neg32(opA) : opA;
        b_mag = neg_b ? neg32(opB) : opB;
    end

    assign accept = (state_q == S_IDLE) && start && !flush;

    logic        early_out;
    logic [31:0] early_res;

`ifdef MULDIV_EARLY_OUT_EN
    logic div_zero_i, ovf_i, mul_zero_i;

    always_comb begin
        div_zero_i = func3[2] && (opB == 32'd0);
        ovf_i      = ((func3 == 3'b100) || (func3 == 3'b110)) &&
                     (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
        mul_zero_i = !func3[2] && ((opA == 32'd0) || (opB == 32'd0));
        early_out  = div_zero_i || ovf_i || mul_zero_i;
        early_res  = 32'd0;
        // func3[1] separates REM/REMU from DIV/DIVU
        if (div_zero_i)
            early_res = func3[1] ? opA : 32'hFFFF_FFFF;
        else if (ovf_i)
            early_res = func3[1] ? 32'd0 : 32'h8000_0000;
    end
`else
    assign early_out = 1'b0;
    assign early_res = 32'd0;
`endif

    // ---------------------------------------------------------------
    // Iteration step
    // ---------------------------------------------------------------
    logic [32:0] add_sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic        div_ok;

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : 33'd0);
        rem_sh  = {hi_q, lo_q[31]};
        trial   = rem_sh - {1'b0, b_mag_q};
        // remainder stays below the divisor, so a clear borrow bit means fit
        div_ok  = !trial[32];
    end

    // ---------------------------------------------------------------
    // Sign fix-up and word select
    // ---------------------------------------------------------------
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] fix_res;

    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? neg64({hi_q, lo_q}) : {hi_q, lo_q};
        quo_s  = (neg_a_q ^ neg_b_q) ? neg32(lo_q) : lo_q;
        rem_s  = neg_a_q ? neg32(hi_q) : hi_q;
        // divisor 0 leaves |A| in the remainder, which the sign fix restores
        // to opA; only the quotient needs forcing
        if (div0_q)
            quo_s = 32'hFFFF_FFFF;
        unique case (func3_q)
            3'b000:                 fix_res = prod_s[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[63:32];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = early_out ? S_DONE : S_RUN;
            S_RUN:  if (cnt_q == 5'd0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush)
            state_d = S_IDLE;
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        // stall is combinational so the pipeline freezes in the accept cycle
        stall    = accept || (state_q == S_RUN) || (state_q == S_FIX);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        result   = result_q;
        resultRd = result_rd_q;
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            func3_q     <= 3'd0;
            rd_q        <= 5'd0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            div0_q      <= 1'b0;
            b_mag_q     <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            cnt_q       <= 5'd0;
            result_q    <= 32'd0;
            result_rd_q <= 5'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        func3_q <= func3;
                        rd_q    <= rdIn;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        div0_q  <= (opB == 32'd0);
                        b_mag_q <= b_mag;
                        hi_q    <= 32'd0;
                        lo_q    <= a_mag;
                        cnt_q   <= 5'd31;
                        if (early_out) begin
                            result_q    <= early_res;
                            result_rd_q <= rdIn;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q != 5'd0)
                        cnt_q <= cnt_q - 5'd1;
                    if (func3_q[2]) begin
                        hi_q <= div_ok ? trial[31:0] : rem_sh[31:0];
                        lo_q <= {lo_q[30:0], div_ok};
                    end else begin
                        hi_q <= add_sum[32:1];
                        lo_q <= {add_sum[0], lo_q[31:1]};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        result_q    <= fix_res;
                        result_rd_q <= rd_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq with a result scoreboard.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  rdIn;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  resultRd;

    always #5 clk = ~clk;

    ex_muldiv_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .func3    (func3),
        .opA      (opA),
        .opB      (opB),
        .rdIn     (rdIn),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .resultRd (resultRd)
    );

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sbv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (f)
            3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'b001: begin p = sa * sbv; return p[63:32]; end
            3'b010: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!EARLY) return 1'b0;
        if (f[2] && b == 0) return 1'b1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        if (!f[2] && (a == 0 || b == 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one operation, holding start through DONE like the stalled pipeline.
    task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
        int   lat;
        int   n;
        int   stall_bad;
        int   d0;
        bit   seen;
        exp_t e;
        lat = is_early(f, a, b) ? 1 : 34;
        sb.push_back('{res: exp, rd: r});
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; func3 = f; opA = a; opB = b; rdIn = r;
        #1 chk({tag, "/accept_stall"}, 64'(stall), 64'd1);
        n = 0; seen = 1'b0; stall_bad = 0;
        while (!seen && n < 60) begin
            @(negedge clk); #1;
            n++;
            if (stall !== (n < lat)) stall_bad++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, "/latency"}, 64'(n), 64'(lat));
        chk({tag, "/stall_profile"}, 64'(stall_bad), 64'd0);
        e = sb.pop_front();
        chk({tag, "/result"}, 64'(result), 64'(e.res));
        chk({tag, "/resultRd"}, 64'(resultRd), 64'(e.rd));
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "/idle_stall"}, 64'(stall), 64'd0);
        @(negedge clk); #1;
        chk({tag, "/no_reaccept"}, 64'(busy), 64'd0);
        chk({tag, "/done_pulses"}, 64'(done_cnt), 64'(d0 + 1));
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          d0;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        func3 = 3'd0; opA = 32'd0; opB = 32'd0; rdIn = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset/stall", 64'(stall), 64'd0);
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
        chk("reset/result", 64'(result), 64'd0);
        chk("reset/resultRd", 64'(resultRd), 64'd0);
        reset = 1'b0;

        op("MUL_m1x3",    3'b000, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'hFFFF_FFFD);
        op("MULHU_m1x3",  3'b011, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'h0000_0002);
        op("MULH_m1x3",   3'b001, 32'hFFFF_FFFF, 32'd3, 5'd5, 32'hFFFF_FFFF);

        // Reset in the middle of a MUL run
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; func3 = 3'b000; opA = 32'd7; opB = 32'd6; rdIn = 5'd9;
        repeat (10) @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk); #1;
        chk("midreset/stall", 64'(stall), 64'd0);
        chk("midreset/busy", 64'(busy), 64'd0);
        chk("midreset/done", 64'(done), 64'd0);
        chk("midreset/result", 64'(result), 64'd0);
        chk("midreset/resultRd", 64'(resultRd), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1 chk("midreset/no_done", 64'(done_cnt), 64'(d0));

        op("DIV_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
        op("REM_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
        op("DIVU_100_7",  3'b101, 32'd100, 32'd7, 5'd8, 32'd14);
        op("REMU_100_7",  3'b111, 32'd100, 32'd7, 5'd9, 32'd2);
        op("DIVU_5_0",    3'b101, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
        op("REM_5_0",     3'b110, 32'd5, 32'd0, 5'd11, 32'd5);
        op("DIV_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
        op("REM_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
        op("MUL_zero",    3'b000, 32'd0, 32'h1234_5678, 5'd14, 32'd0);
        op("MULHSU_m2_3", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE);

        // Flush during a DIV run, then a fresh request two cycles later
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; func3 = 3'b100; opA = 32'hFFFF_FFF9; opB = 32'd2; rdIn = 5'd20;
        repeat (20) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk); #1;
        chk("flush/busy", 64'(busy), 64'd0);
        chk("flush/stall", 64'(stall), 64'd0);
        chk("flush/no_done", 64'(done_cnt), 64'(d0));
        flush = 1'b0;
        op("after_flush", 3'b101, 32'd1000, 32'd33, 5'd21, 32'd30);

        for (int i = 0; i < 8; i++) begin
            rf = 3'(i);
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            if (i == 4) rb = rb >> 20;
            op($sformatf("rand%0d_f%0d", i, i), rf, ra, rb, 5'(i + 1), model(rf, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer for the execute stage, implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in EX and takes forwarded operands from the EX operand muxes. It runs a radix-2 shift-add multiply or restoring divide over multiple cycles. While it runs it holds the IF/ID/ID-EX registers through a stall request, then returns the result and destination register for the EX/MEM register.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  operation request from ID/EX (M-extension instruction in EX)
- func3  input  3  RV32M selector: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opA  input  32  forwarded rs1 value
- opB  input  32  forwarded rs2 value
- rdIn  input  5  destination register of the requesting instruction
- flush  input  1  abort current operation (branch/exception squash)
- stall  output  1  hold upstream pipeline registers
- busy  output  1  sequencer not IDLE
- done  output  1  one-cycle pulse: result/resultRd valid
- result  output  32  operation result
- resultRd  output  5  destination register captured at start

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1 (and flush=0), latch func3, rdIn, and the operand magnitudes/signs, clear the accumulator, load iteration counter = 31, go to RUN. Signedness per func3: MULH both signed; MULHSU A signed, B unsigned; DIV/REM both signed; others unsigned.
- RUN: one iteration per cycle; counter decrements; at counter==0 go to FIX.
  - MUL*: 64-bit product of magnitudes by shift-add.
  - DIV*: restoring division of magnitudes.
- FIX: apply sign correction.
  - Product negated if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend sign.
  - Select low word (MUL), high word (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU). Go to DONE.
- DONE: done=1, result/resultRd driven; next state IDLE.
- RISC-V special cases, mandatory regardless of configuration:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = opA.
  - Signed overflow (opA=0x80000000, opB=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- start while busy is ignored. The held pipeline keeps start asserted through DONE. In the cycle after DONE, the ID/EX register has advanced, so the same instruction is not re-accepted.
- flush in any state: next state IDLE, no done pulse. flush has priority over start in IDLE.
- reset has priority over flush and start.

## Timing
- Reset values: state IDLE, stall=0, busy=0, done=0, result=0, resultRd=0, counter=0.
- start sampled at edge k:
  - RUN occupies cycles k+1..k+32.
  - FIX is cycle k+33.
  - DONE (done=1) is cycle k+34.
- Fixed latency: 34 cycles after acceptance.
- stall = (state==IDLE & start & ~flush) | (state==RUN) | (state==FIX). It is combinational so the pipeline holds in the acceptance cycle. It is 0 in DONE so EX/MEM captures the result at the end of the DONE cycle.
- busy = state != IDLE.
- result and resultRd are registered and hold their value after DONE until the next FIX. done is asserted only in DONE.
- flush during cycle k+j: state is IDLE at k+j+1, stall deasserts in that cycle, and the captured rd is discarded.

## Configuration
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: the following go IDLE→DONE directly at cycle k+1 (latency 1; stall high only in the acceptance cycle):
  - divide by zero;
  - signed overflow;
  - any multiply with opA==0 or opB==0 (result 0).
- Undefined: all operations take the full 34-cycle path; special-case results are produced in FIX.

## Test plan
- Reset mid-RUN: MUL 7×6 started, reset asserted at cycle k+10 → next cycle all outputs at reset values, no done pulse.
- MUL opA=0xFFFFFFFF (-1), opB=3, rdIn=5 → done at k+34, result=0xFFFFFFFD, resultRd=5. MULHU with the same operands → 0x00000002. MULH → 0xFFFFFFFF.
- DIV opA=-7 (0xFFFFFFF9), opB=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - Latency 1 with MULDIV_EARLY_OUT_EN, 34 without.
- flush asserted at k+20 during DIV → IDLE at k+21, stall=0, no done. A new start at k+22 completes normally at k+56.
- Stall profile: start held continuously → stall high for cycles k..k+33 and low at k+34. Exactly one done pulse; no re-acceptance at k+35 once start drops.
